// File: rtl/counter_seq_ctrl.sv
// Sequencer for a 4-bit load/up/down counter: repeated sweeps from a start value
// to an end value, one step every STEP_DIV+1 cycles, with abort and completion pulse.
//
// state | meaning
// IDLE  | waiting for START, counter held
// LOAD  | counter loads the shadow start value
// RUN   | stepping the counter until Q reaches the shadow end value
// FIN   | one-cycle DONE pulse, then back to IDLE
module counter_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int DIV_W  = 8,
  parameter int LOOP_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic              DIR,
  input  logic [WIDTH-1:0]  START_VAL,
  input  logic [WIDTH-1:0]  END_VAL,
  input  logic [DIV_W-1:0]  STEP_DIV,
  input  logic [LOOP_W-1:0] LOOPS,
  input  logic [WIDTH-1:0]  Q_IN,
  output logic              CNT_EN,
  output logic [1:0]        CNT_S,
  output logic [WIDTH-1:0]  CNT_D,
  output logic              BUSY,
  output logic              DONE,
  output logic [LOOP_W-1:0] LOOP_LEFT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t            state;
  logic              dir_q;
  logic [WIDTH-1:0]  start_q;
  logic [WIDTH-1:0]  end_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  presc;
  logic [LOOP_W-1:0] loop_left;

  logic at_end;
  logic step_due;

  assign at_end   = (Q_IN == end_q);
  assign step_due = (presc == div_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      dir_q     <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      div_q     <= '0;
      presc     <= '0;
      loop_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            dir_q     <= DIR;
            start_q   <= START_VAL;
            end_q     <= END_VAL;
            div_q     <= STEP_DIV;
            loop_left <= LOOPS;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (ABORT) begin
            state <= ST_IDLE;
          end else begin
            presc <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // end detection outranks a pending step so the sweep never overshoots
          if (ABORT) begin
            state <= ST_IDLE;
          end else if (at_end) begin
            if (loop_left != '0) begin
              loop_left <= loop_left - LOOP_W'(1);
              state     <= ST_LOAD;
            end else begin
              state <= ST_FIN;
            end
          end else if (step_due) begin
            presc <= '0;
          end else begin
            presc <= presc + DIV_W'(1);
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counter controls are a decode of registered state; only ABORT and Q_IN gate EN.
  always_comb begin
    CNT_EN = 1'b0;
    CNT_S  = 2'b00;
    CNT_D  = start_q;
    case (state)
      ST_LOAD: begin
        CNT_S  = 2'b01;
        CNT_EN = ~ABORT;
      end
      ST_RUN: begin
        CNT_S  = {1'b1, dir_q};
        CNT_EN = ~ABORT & ~at_end & step_due;
      end
      default: begin
        CNT_EN = 1'b0;
        CNT_S  = 2'b00;
      end
    endcase
  end

  assign BUSY      = (state == ST_LOAD) || (state == ST_RUN);
  assign DONE      = (state == ST_FIN);
  assign LOOP_LEFT = loop_left;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: a behavioural counter drives Q_IN and an
// arithmetic timeline model predicts every load, step and done event.
module tb_counter_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic       DIR = 1'b0;
  logic [3:0] START_VAL = '0;
  logic [3:0] END_VAL = '0;
  logic [7:0] STEP_DIV = '0;
  logic [3:0] LOOPS = '0;
  logic [3:0] Q_IN;
  logic       CNT_EN;
  logic [1:0] CNT_S;
  logic [3:0] CNT_D;
  logic       BUSY;
  logic       DONE;
  logic [3:0] LOOP_LEFT;

  counter_seq_ctrl #(.WIDTH(4), .DIV_W(8), .LOOP_W(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .DIR(DIR),
    .START_VAL(START_VAL), .END_VAL(END_VAL), .STEP_DIV(STEP_DIV), .LOOPS(LOOPS),
    .Q_IN(Q_IN), .CNT_EN(CNT_EN), .CNT_S(CNT_S), .CNT_D(CNT_D),
    .BUSY(BUSY), .DONE(DONE), .LOOP_LEFT(LOOP_LEFT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // behavioural load/up/down counter sharing the reset
  logic [3:0] q_model;
  assign Q_IN = q_model;
  always @(posedge CLK or posedge RST) begin
    if (RST) q_model <= '0;
    else if (CNT_EN) begin
      case (CNT_S)
        2'b01: q_model <= CNT_D;
        2'b10: q_model <= q_model + 4'd1;
        2'b11: q_model <= q_model - 4'd1;
        default: q_model <= q_model;
      endcase
    end
  end

  typedef struct {
    int         kind;   // 0 load, 1 step, 2 done
    int         cyc;
    logic [1:0] s;
    logic [3:0] d;
    logic [3:0] ll;
  } ev_t;

  ev_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge CLK) begin
    ev_t e;
    int  k;
    if (!RST && (CNT_EN || DONE)) begin
      k = DONE ? 2 : ((CNT_S == 2'b01) ? 0 : 1);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d kind=%0d en=%0b s=%0b", cyc, k, CNT_EN, CNT_S);
      end else begin
        e = sb.pop_front();
        if (k != e.kind || cyc != e.cyc || LOOP_LEFT != e.ll || BUSY != (e.kind != 2) ||
            (e.kind != 2 && (CNT_S != e.s || CNT_D != e.d)) || (e.kind == 2 && CNT_EN)) begin
          n_bad++;
          $display("FAIL event: got kind=%0d cyc=%0d s=%0b d=%0d ll=%0d busy=%0b en=%0b, want kind=%0d cyc=%0d s=%0b d=%0d ll=%0d",
                   k, cyc, CNT_S, CNT_D, LOOP_LEFT, BUSY, CNT_EN, e.kind, e.cyc, e.s, e.d, e.ll);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // mode 0: normal, 1: abort at c0+off, 2: reset at c0+off; off<0 picks a random point
  task automatic run_cmd(input bit dir, input int sv, input int ev, input int div,
                         input int loops, input int mode, input int off, input bit noise);
    int  c0, n, lc, done_c, cut, budget, o;
    ev_t tmp[$];
    ev_t e;
    bit  fin;
    budget = 0;
    do begin
      @(posedge CLK); #2;
      budget++;
    end while ((BUSY || DONE) && budget < 5000);
    check("idle_wait", {31'd0, BUSY | DONE}, 32'd0);
    c0 = cyc;
    n  = dir ? ((sv - ev) & 15) : ((ev - sv) & 15);
    lc = c0 + 1;
    for (int p = 0; p <= loops; p++) begin
      e.kind = 0; e.cyc = lc; e.s = 2'b01; e.d = 4'(sv); e.ll = 4'(loops - p);
      tmp.push_back(e);
      for (int k = 0; k < n; k++) begin
        e.kind = 1; e.cyc = lc + 1 + k * (div + 1) + div; e.s = {1'b1, dir};
        tmp.push_back(e);
      end
      lc = lc + 2 + n * (div + 1);
    end
    done_c = lc;
    e.kind = 2; e.cyc = done_c; e.s = 2'b00; e.d = 4'(sv); e.ll = 4'd0;
    tmp.push_back(e);
    o   = (off < 0) ? int'($urandom_range(1, done_c - c0 - 1)) : off;
    cut = (mode == 0) ? done_c + 1 : c0 + o;
    foreach (tmp[i]) if (tmp[i].cyc < cut) sb.push_back(tmp[i]);

    DIR = dir; START_VAL = 4'(sv); END_VAL = 4'(ev); STEP_DIV = 8'(div); LOOPS = 4'(loops);
    START = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < done_c - c0 + 8 && !fin; i++) begin
      @(posedge CLK); #2;
      START = noise && (cyc == c0 + 1 || (mode == 0 && cyc == done_c));
      if (noise) begin
        DIR = $urandom_range(0, 1); START_VAL = 4'($urandom); END_VAL = 4'($urandom);
        STEP_DIV = 8'($urandom); LOOPS = 4'($urandom);
      end
      ABORT = (mode == 1 && cyc == cut);
      if (mode == 1 && cyc == cut + 1) check("abort_busy", {31'd0, BUSY}, 32'd0);
      if (mode == 2 && cyc == cut) begin
        RST = 1'b1;
        #1;
        check("rst_async", {19'd0, CNT_EN, CNT_S, CNT_D, BUSY, DONE, LOOP_LEFT}, 32'd0);
        @(posedge CLK); @(posedge CLK); #2;
        RST = 1'b0;
        fin = 1'b1;
      end
      if (mode != 2 && cyc >= cut && !BUSY && !DONE) fin = 1'b1;
    end
    START = 1'b0;
    ABORT = 1'b0;
    check("drain", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #12;
    check("reset_state", {19'd0, CNT_EN, CNT_S, CNT_D, BUSY, DONE, LOOP_LEFT}, 32'd0);
    @(posedge CLK); #2;
    RST = 1'b0;

    run_cmd(1'b0, 3, 6, 0, 0, 0, 0, 1'b0);
    run_cmd(1'b1, 1, 14, 2, 0, 0, 0, 1'b1);
    run_cmd(1'b0, 0, 2, 0, 2, 0, 0, 1'b0);
    run_cmd(1'b0, 9, 9, 0, 0, 0, 0, 1'b1);
    run_cmd(1'b0, 14, 2, 1, 0, 0, 0, 1'b0);
    run_cmd(1'b0, 0, 10, 3, 0, 1, 9, 1'b1);
    run_cmd(1'b1, 7, 3, 1, 1, 1, 1, 1'b0);
    run_cmd(1'b0, 0, 5, 5, 0, 2, 12, 1'b0);
    run_cmd(1'b0, 3, 6, 0, 0, 0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int m;
      m = ($urandom_range(0, 9) < 2) ? 1 : 0;
      run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), m, -1,
              1'($urandom_range(0, 1)));
    end
    run_cmd(1'b1, 12, 4, 2, 1, 2, -1, 1'b0);
    run_cmd(1'b0, 5, 8, 1, 0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencer that drives the EN/S/D control pins of the 4-bit load/up/down counter. Runs a programmed sweep from a start value to an end value at a programmable step rate, repeated a programmed number of times. Sits between the host/control logic and the counter; observes the counter output Q to detect the end value.

Parameters:
WIDTH, 4, counter data width (matches counter Q/D)
DIV_W, 8, width of step-rate divider
LOOP_W, 4, width of repeat count

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-high (shared with counter)
START  input  1  command strobe; sampled only in IDLE
ABORT  input  1  cancel running sequence
DIR  input  1  0 = count up (S=10), 1 = count down (S=11)
START_VAL  input  WIDTH  value loaded into counter at start of each pass
END_VAL  input  WIDTH  terminal value ending a pass
STEP_DIV  input  DIV_W  one step every STEP_DIV+1 cycles
LOOPS  input  LOOP_W  number of extra passes after the first
Q_IN  input  WIDTH  counter output Q
CNT_EN  output  1  to counter EN
CNT_S  output  2  to counter S
CNT_D  output  WIDTH  to counter D
BUSY  output  1  high in LOAD and RUN
DONE  output  1  one-cycle completion pulse
LOOP_LEFT  output  LOOP_W  passes remaining after current

Behaviour:
- Reset: Q-state IDLE; CNT_EN=0, CNT_S=00, CNT_D=0, BUSY=0, DONE=0, LOOP_LEFT=0, prescaler=0, shadow regs=0.
- Outputs: decoded from registered state, prescaler and shadow regs; no combinational path from START/ABORT to CNT_* except ABORT gating (below).
- States: IDLE, LOAD, RUN, FIN.
- IDLE: CNT_EN=0, CNT_S=00. START=1 -> capture DIR, START_VAL, END_VAL, STEP_DIV into shadow regs, LOOP_LEFT<=LOOPS; next LOAD. All command inputs ignored outside IDLE.
- LOAD (1 cycle): CNT_EN=1, CNT_S=01, CNT_D=shadow START_VAL; prescaler<=0; next RUN.
- RUN: each cycle, in priority order:
  1. ABORT=1 -> CNT_EN=0; next IDLE; no DONE; counter keeps current value.
  2. Q_IN==END_VAL -> CNT_EN=0; if LOOP_LEFT>0: LOOP_LEFT-1, next LOAD; else next FIN.
  3. prescaler==STEP_DIV -> CNT_EN=1, CNT_S=10 (DIR=0) or 11 (DIR=1); prescaler<=0.
  4. else CNT_EN=0, prescaler+1.
- Step timing: first RUN cycle has prescaler=0; a pass of N steps occupies N*(STEP_DIV+1)+1 RUN cycles; the final cycle is end detection.
- ABORT in LOAD: same as in RUN, with CNT_EN=0 that cycle (no load).
- FIN (1 cycle): DONE=1, BUSY=0, CNT_EN=0; next IDLE. START during FIN is ignored.
- Wrap-around: counter wraps modulo 2^WIDTH; no direction check. Up from 14 to 2 takes 4 steps (14,15,0,1,2).
- START_VAL==END_VAL: zero steps, 1 RUN cycle per pass.
- CNT_D holds shadow START_VAL when CNT_S!=01; the counter ignores it.
- RST mid-operation: immediate return to reset values; counter reset by the same RST.

Test Plan:
- RST asserted during RUN at STEP_DIV=5 -> all outputs 0 asynchronously, IDLE after release; START next cycle accepted.
- DIR=0, START_VAL=3, END_VAL=6, STEP_DIV=0, LOOPS=0, START at cycle 0 -> cycle 1 CNT_S=01/CNT_D=3/EN=1; cycles 2-4 EN=1, S=10; Q_IN 3,4,5,6; cycle 5 EN=0; cycle 6 DONE=1 for one cycle.
- DIR=1, START_VAL=1, END_VAL=14, STEP_DIV=2 -> Q sequence 1,0,15,14; EN pulses exactly 3 cycles apart; RUN lasts 10 cycles; one DONE.
- LOOPS=2, START_VAL=0, END_VAL=2, up, STEP_DIV=0 -> three LOAD cycles; LOOP_LEFT 2->1->0; 6 total step pulses; single DONE at end.
- START_VAL=END_VAL=9 -> LOAD, 1 RUN cycle, FIN; zero step pulses; DONE 3 cycles after START.
- ABORT coincident with a step cycle in RUN -> CNT_EN=0 that cycle, BUSY=0 next cycle, no DONE; START pulsed while BUSY earlier has no effect.
